// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: tick-stepped row/column lamp plan with per-direction seconds-remaining.
// Define TRAFFIC_NIGHT_FLASH_EN to add the night input and the flashing-yellow FLASH state.
module traffic_phase_sequencer #(
   parameter int ROW_GREEN_TIME  = 25,
   parameter int ROW_YELLOW_TIME = 5,
   parameter int COL_GREEN_TIME  = 20,
   parameter int COL_YELLOW_TIME = 4,
   parameter int ALL_RED_TIME    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic [2:0] row_traffic_lights,
   output logic [2:0] column_traffic_lights,
   output logic [6:0] row_seconds,
   output logic [6:0] column_seconds,
   output logic [2:0] phase
);
   localparam logic [6:0] RG = 7'(ROW_GREEN_TIME);
   localparam logic [6:0] RY = 7'(ROW_YELLOW_TIME);
   localparam logic [6:0] CG = 7'(COL_GREEN_TIME);
   localparam logic [6:0] CY = 7'(COL_YELLOW_TIME);
   localparam logic [6:0] AR = 7'(ALL_RED_TIME);

   typedef enum logic [2:0] {
      ROW_G = 3'd0,
      ROW_Y = 3'd1,
      RED1  = 3'd2,
      COL_G = 3'd3,
      COL_Y = 3'd4,
`ifdef TRAFFIC_NIGHT_FLASH_EN
      RED2  = 3'd5,
      FLASH = 3'd6
`else
      RED2  = 3'd5
`endif
   } state_t;

   state_t     state, nxt;
   logic [6:0] timer;
   logic       legal;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic       blink;
`endif

   // saturating 8-bit add; chaining keeps every partial sum within 8 bits
   function automatic logic [6:0] add(input logic [6:0] a, input logic [6:0] b);
      logic [7:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > 8'd99) ? 7'd99 : s[6:0];
   endfunction

   function automatic logic [6:0] dur(input state_t s);
      return (s == ROW_Y) ? RY : (s == COL_G) ? CG : (s == COL_Y) ? CY :
             (s == RED1 || s == RED2) ? AR : RG;
   endfunction

   assign nxt = (state == ROW_G) ? ROW_Y :
                (state == ROW_Y) ? ((AR == 7'd0) ? COL_G : RED1) :
                (state == RED1)  ? COL_G :
                (state == COL_G) ? COL_Y :
                (state == COL_Y) ? ((AR == 7'd0) ? ROW_G : RED2) : ROW_G;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   assign legal = state != 3'd7;
`else
   assign legal = state <= RED2;
`endif
   assign phase = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ROW_G;
         timer <= RG;
`ifdef TRAFFIC_NIGHT_FLASH_EN
         blink <= 1'b1;
      end else if (tick && night) begin
         state <= FLASH;
         timer <= RG;
         blink <= (state == FLASH) ? ~blink : blink;
      end else if (state == FLASH) begin
         if (tick) begin
            state <= ROW_G;
            timer <= RG;
            blink <= 1'b1;
         end
`endif
      end else if (!legal || timer == 7'd0) begin
         state <= ROW_G;
         timer <= RG;
      end else if (tick) begin
         if (timer > 7'd1) timer <= timer - 7'd1;
         else begin
            state <= nxt;
            timer <= dur(nxt);
         end
      end
   end

   // the red direction counts down through every phase left before its own green
   always_comb begin
      row_traffic_lights    = 3'b100;
      column_traffic_lights = 3'b100;
      row_seconds           = timer;
      column_seconds        = timer;
      case (state)
         ROW_G: begin
            row_traffic_lights = 3'b001;
            column_seconds     = add(add(timer, RY), AR);
         end
         ROW_Y: begin
            row_traffic_lights = 3'b010;
            column_seconds     = add(timer, AR);
         end
         RED1:  row_seconds = add(add(add(timer, CG), CY), AR);
         COL_G: begin
            column_traffic_lights = 3'b001;
            row_seconds           = add(add(timer, CY), AR);
         end
         COL_Y: begin
            column_traffic_lights = 3'b010;
            row_seconds           = add(timer, AR);
         end
         RED2:  column_seconds = add(add(add(timer, RG), RY), AR);
`ifdef TRAFFIC_NIGHT_FLASH_EN
         FLASH: begin
            row_traffic_lights    = blink ? 3'b010 : 3'b000;
            column_traffic_lights = blink ? 3'b010 : 3'b000;
            row_seconds           = 7'd0;
            column_seconds        = 7'd0;
         end
`endif
         default: ;
      endcase
   end
endmodule
